// File: rtl/norm_seq.sv
// rtl/norm_seq.sv - tile sequencer for the RMSNorm-1 controller over a multi-tile hidden dimension
//
// Walks the K-column tiles of one M-row block in three phases:
//   phase 1: read each input tile, pulse start1, wait out busy_norm1
//   phase 2: pulse start1_sum once, wait out busy_norm1
//   phase 3: re-read each tile, pulse start2, wait, write the scaled tile back
//
// Optional feature macro: NORM_SEQ_TIMEOUT_EN (per-wait watchdog of TIMEOUT cycles).
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cfg_start                   pulse, begin a pass (accepted only when idle)
//   cfg_ntile                   number of tiles in the pass
//   cfg_rd_base, cfg_wr_base    first input / output tile address
//   busy_norm1                  norm controller busy
//   start1, start1_sum, start2  single-cycle phase start pulses
//   sram_rd_en, sram_rd_addr    tile read strobe and address
//   sram_wr_en, sram_wr_addr    tile write strobe and address
//   busy                        pass in progress
//   done                        single-cycle end-of-pass pulse
//   err                         sticky error flag, cleared by an accepted cfg_start

module norm_seq #(
  parameter int ADDR_W  = 12,
  parameter int NT_W    = 6,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [NT_W-1:0]   cfg_ntile,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic              busy_norm1,
  output logic              start1,
  output logic              start1_sum,
  output logic              start2,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD1, S_LAT1, S_ISS1, S_WAIT1, S_SUM, S_WAITS,
    S_RD2, S_LAT2, S_ISS2, S_WAIT2, S_WB, S_DONE
  } state_t;

  // LAT states hold RD_LAT-1 cycles: counter runs RD_LAT-2 down to 0.
  localparam logic [1:0] LAT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t            state_q, state_d;
  logic [NT_W-1:0]   t_q, t_d;
  logic [NT_W-1:0]   ntile_q, ntile_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [1:0]        lat_q, lat_d;
  logic              wfirst_q, wfirst_d;
  logic              start1_q, start1_d;
  logic              start1_sum_q, start1_sum_d;
  logic              start2_q, start2_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic last_tile;
  logic wait_exit;
  logic wait_abort;
  logic in_wait;

  assign last_tile = (t_q == ntile_q - NT_W'(1));
  assign in_wait   = (state_q == S_WAIT1) || (state_q == S_WAITS) || (state_q == S_WAIT2);
  // The controller registers its busy, so the first wait cycle after a start
  // still shows the previous (idle) value and must not end the wait.
  assign wait_exit = !wfirst_q && !busy_norm1;

`ifdef NORM_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign wait_abort = in_wait && !wfirst_q && busy_norm1 && (tmo_q == '0);

  always_comb begin
    tmo_d = tmo_q;
    if (wfirst_d) begin
      tmo_d = TMO_W'(TIMEOUT);
    end else if (in_wait && (tmo_q != '0)) begin
      tmo_d = tmo_q - TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0) && in_wait;
  assign wait_abort     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    ntile_d   = ntile_q;
    rd_base_d = rd_base_q;
    wr_base_d = wr_base_q;
    lat_d     = lat_q;
    wfirst_d  = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          ntile_d   = cfg_ntile;
          rd_base_d = cfg_rd_base;
          wr_base_d = cfg_wr_base;
          t_d       = '0;
          if (cfg_ntile == '0) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_RD1;
            err_d   = 1'b0;
          end
        end
      end
      S_RD1: begin
        state_d = (RD_LAT > 1) ? S_LAT1 : S_ISS1;
        lat_d   = LAT_INIT;
      end
      S_LAT1: begin
        if (lat_q == 2'd0) state_d = S_ISS1;
        else               lat_d   = lat_q - 2'd1;
      end
      S_ISS1: begin
        state_d  = S_WAIT1;
        wfirst_d = 1'b1;
      end
      S_WAIT1: begin
        if (wait_abort) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (wait_exit) begin
          if (last_tile) begin
            state_d = S_SUM;
          end else begin
            t_d     = t_q + NT_W'(1);
            state_d = S_RD1;
          end
        end
      end
      S_SUM: begin
        t_d      = '0;
        state_d  = S_WAITS;
        wfirst_d = 1'b1;
      end
      S_WAITS: begin
        if (wait_abort) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (wait_exit) begin
          state_d = S_RD2;
        end
      end
      S_RD2: begin
        state_d = (RD_LAT > 1) ? S_LAT2 : S_ISS2;
        lat_d   = LAT_INIT;
      end
      S_LAT2: begin
        if (lat_q == 2'd0) state_d = S_ISS2;
        else               lat_d   = lat_q - 2'd1;
      end
      S_ISS2: begin
        state_d  = S_WAIT2;
        wfirst_d = 1'b1;
      end
      S_WAIT2: begin
        if (wait_abort) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (wait_exit) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (last_tile) begin
          state_d = S_DONE;
        end else begin
          t_d     = t_q + NT_W'(1);
          state_d = S_RD2;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A start request while a pass is running is dropped but flagged.
    if (cfg_start && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they are registered and line
  // up exactly with the state they belong to.
  always_comb begin
    start1_d     = (state_d == S_ISS1);
    start1_sum_d = (state_d == S_SUM);
    start2_d     = (state_d == S_ISS2);
    rd_en_d      = (state_d == S_RD1) || (state_d == S_RD2);
    wr_en_d      = (state_d == S_WB);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    rd_addr_d    = rd_en_d ? (rd_base_d + ADDR_W'(t_d)) : rd_addr_q;
    wr_addr_d    = wr_en_d ? (wr_base_d + ADDR_W'(t_d)) : wr_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      ntile_q      <= '0;
      rd_base_q    <= '0;
      wr_base_q    <= '0;
      lat_q        <= 2'd0;
      wfirst_q     <= 1'b0;
      start1_q     <= 1'b0;
      start1_sum_q <= 1'b0;
      start2_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      ntile_q      <= ntile_d;
      rd_base_q    <= rd_base_d;
      wr_base_q    <= wr_base_d;
      lat_q        <= lat_d;
      wfirst_q     <= wfirst_d;
      start1_q     <= start1_d;
      start1_sum_q <= start1_sum_d;
      start2_q     <= start2_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign start1       = start1_q;
  assign start1_sum   = start1_sum_q;
  assign start2       = start2_q;
  assign sram_rd_en   = rd_en_q;
  assign sram_wr_en   = wr_en_q;
  assign sram_rd_addr = rd_addr_q;
  assign sram_wr_addr = wr_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_norm_seq.sv
// tb/tb_norm_seq.sv - scoreboard bench for norm_seq (RD_LAT=1 and RD_LAT=3 instances)

module tb_norm_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cfg_start;
  logic [5:0]  cfg_ntile;
  logic [11:0] cfg_rd_base;
  logic [11:0] cfg_wr_base;
  logic        busy_norm1;
  logic        sel;
  logic        cfg_start_a, cfg_start_b;

  assign cfg_start_a = cfg_start & ~sel;
  assign cfg_start_b = cfg_start & sel;

  logic        a_start1, a_start1_sum, a_start2, a_rd_en, a_wr_en, a_busy, a_done, a_err;
  logic [11:0] a_rd_addr, a_wr_addr;
  logic        b_start1, b_start1_sum, b_start2, b_rd_en, b_wr_en, b_busy, b_done, b_err;
  logic [11:0] b_rd_addr, b_wr_addr;

  norm_seq #(.ADDR_W(12), .NT_W(6), .RD_LAT(1), .TIMEOUT(8)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start_a), .cfg_ntile(cfg_ntile),
    .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base), .busy_norm1(busy_norm1),
    .start1(a_start1), .start1_sum(a_start1_sum), .start2(a_start2),
    .sram_rd_en(a_rd_en), .sram_wr_en(a_wr_en),
    .sram_rd_addr(a_rd_addr), .sram_wr_addr(a_wr_addr),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  norm_seq #(.ADDR_W(12), .NT_W(6), .RD_LAT(3), .TIMEOUT(8)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start_b), .cfg_ntile(cfg_ntile),
    .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base), .busy_norm1(busy_norm1),
    .start1(b_start1), .start1_sum(b_start1_sum), .start2(b_start2),
    .sram_rd_en(b_rd_en), .sram_wr_en(b_wr_en),
    .sram_rd_addr(b_rd_addr), .sram_wr_addr(b_wr_addr),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  logic        mon_start1, mon_start1_sum, mon_start2, mon_rd_en, mon_wr_en;
  logic        mon_busy, mon_done, mon_err;
  logic [11:0] mon_rd_addr, mon_wr_addr;
  logic [63:0] a_vec, b_vec;

  assign mon_start1     = sel ? b_start1     : a_start1;
  assign mon_start1_sum = sel ? b_start1_sum : a_start1_sum;
  assign mon_start2     = sel ? b_start2     : a_start2;
  assign mon_rd_en      = sel ? b_rd_en      : a_rd_en;
  assign mon_wr_en      = sel ? b_wr_en      : a_wr_en;
  assign mon_busy       = sel ? b_busy       : a_busy;
  assign mon_done       = sel ? b_done       : a_done;
  assign mon_err        = sel ? b_err        : a_err;
  assign mon_rd_addr    = sel ? b_rd_addr    : a_rd_addr;
  assign mon_wr_addr    = sel ? b_wr_addr    : a_wr_addr;
  assign a_vec = {32'b0, a_start1, a_start1_sum, a_start2, a_rd_en, a_wr_en,
                  a_busy, a_done, a_err, a_rd_addr, a_wr_addr};
  assign b_vec = {32'b0, b_start1, b_start1_sum, b_start2, b_rd_en, b_wr_en,
                  b_busy, b_done, b_err, b_rd_addr, b_wr_addr};

  localparam logic [3:0] K_RD = 4'd1, K_WR = 4'd2, K_S1 = 4'd3, K_SS = 4'd4, K_S2 = 4'd5, K_DN = 4'd6;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  int          cyc     = 0;
  int          last_rd = 0;
  int          b1 = 19, bs = 6, b2 = 4;
  int          rem;
  logic        stuck_arm = 1'b0;
  logic        stuck;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pass(input int nt, input logic [11:0] rb, input logic [11:0] wb);
    logic [11:0] a;
    if (nt > 0) begin
      for (int t = 0; t < nt; t++) begin
        a = rb + 12'(t);
        sb.push_back({K_RD, a});
        sb.push_back({K_S1, 12'h000});
      end
      sb.push_back({K_SS, 12'h000});
      for (int t = 0; t < nt; t++) begin
        a = rb + 12'(t);
        sb.push_back({K_RD, a});
        sb.push_back({K_S2, 12'h000});
        a = wb + 12'(t);
        sb.push_back({K_WR, a});
      end
    end
    sb.push_back({K_DN, 12'h000});
  endtask

  task automatic pulse_start(input int nt, input logic [11:0] rb, input logic [11:0] wb);
    @(negedge clk);
    cfg_ntile   = 6'(nt);
    cfg_rd_base = rb;
    cfg_wr_base = wb;
    cfg_start   = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("busy_rise", 64'(mon_busy), 64'd1);
    chk("err_on_accept", 64'(mon_err), 64'(nt == 0));
    chk("done_latency", 64'(mon_done), 64'(nt == 0));
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000; i++) begin
      if (n_done != d0) break;
      @(negedge clk);
    end
    chk("done_count", 64'(n_done - d0), 64'd1);
    repeat (3) @(negedge clk);
    chk("busy_fall", 64'(mon_busy), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_pass(input logic s, input int nt, input logic [11:0] rb, input logic [11:0] wb);
    int d0;
    sel = s;
    d0  = n_done;
    push_pass(nt, rb, wb);
    pulse_start(nt, rb, wb);
    wait_done(d0);
  endtask

  // Controller model: busy registered, high for B cycles starting the cycle after a start pulse.
  initial begin
    rem        = 0;
    stuck      = 1'b0;
    busy_norm1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!stuck_arm) stuck = 1'b0;
      if (!rst_n) begin
        rem        = 0;
        busy_norm1 = 1'b0;
      end else if (mon_start1 || mon_start1_sum || mon_start2) begin
        rem = mon_start1 ? b1 : (mon_start1_sum ? bs : b2);
        if (mon_start1 && stuck_arm) stuck = 1'b1;
        busy_norm1 = stuck;
      end else if (rem > 0) begin
        busy_norm1 = 1'b1;
        rem--;
      end else begin
        busy_norm1 = stuck;
      end
    end
  end

  // Output monitor: every strobe/pulse is popped against the scoreboard.
  initial begin
    int          n_ev;
    logic [15:0] got, exp;
    forever begin
      @(negedge clk);
      cyc++;
      n_ev = int'(mon_rd_en) + int'(mon_wr_en) + int'(mon_start1) + int'(mon_start1_sum)
           + int'(mon_start2) + int'(mon_done);
      if (n_ev != 0) begin
        chk("one_event_per_cycle", 64'(n_ev), 64'd1);
        if (mon_rd_en)           got = {K_RD, mon_rd_addr};
        else if (mon_wr_en)      got = {K_WR, mon_wr_addr};
        else if (mon_start1)     got = {K_S1, 12'h000};
        else if (mon_start1_sum) got = {K_SS, 12'h000};
        else if (mon_start2)     got = {K_S2, 12'h000};
        else                     got = {K_DN, 12'h000};
        exp = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
        chk("event", 64'(got), 64'(exp));
        if (mon_start1 || mon_start2) chk("rd_to_start", 64'(cyc - last_rd), sel ? 64'd3 : 64'd1);
        if (mon_done) n_done++;
      end
      if (mon_rd_en) last_rd = cyc;
    end
  end

  initial begin
    int d0;
    rst_n       = 1'b0;
    cfg_start   = 1'b0;
    cfg_ntile   = '0;
    cfg_rd_base = '0;
    cfg_wr_base = '0;
    sel         = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_l1", a_vec, 64'd0);
    chk("reset_outs_l3", b_vec, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-tile pass, controller busy 19/6/4.
    run_pass(1'b0, 2, 12'h010, 12'h100);

    // Single tile at the top of the address space, RD_LAT=3.
    run_pass(1'b1, 1, 12'hFFF, 12'hFFF);

    // cfg_start during the first WAIT1 is dropped and flags err.
    sel = 1'b0;
    d0  = n_done;
    push_pass(2, 12'h020, 12'h200);
    pulse_start(2, 12'h020, 12'h200);
    for (int i = 0; i < 50; i++) begin
      if (mon_start1) break;
      @(negedge clk);
    end
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("err_midpass", 64'(mon_err), 64'd1);
    wait_done(d0);
    chk("err_sticky", 64'(mon_err), 64'd1);

    // Next accepted start clears err; zero-length start2 busy window.
    b2 = 0;
    run_pass(1'b0, 1, 12'h030, 12'h300);
    chk("err_cleared", 64'(mon_err), 64'd0);
    b2 = 4;

    // ntile=0: no strobes, done next cycle, err set.
    run_pass(1'b0, 0, 12'h040, 12'h400);
    chk("err_ntile0", 64'(mon_err), 64'd1);

    // Reset during WAITS aborts the pass silently.
    sel = 1'b0;
    push_pass(2, 12'h050, 12'h500);
    pulse_start(2, 12'h050, 12'h500);
    for (int i = 0; i < 200; i++) begin
      if (mon_start1_sum) break;
      @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_midpass_outs", a_vec, 64'd0);
    sb.delete();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("reset_quiet_busy", 64'(mon_busy), 64'd0);

    // Clean pass after reset, read addresses wrap past 0xFFF.
    run_pass(1'b0, 3, 12'hFFE, 12'h0FF);

`ifdef NORM_SEQ_TIMEOUT_EN
    // Controller stuck busy after start1: watchdog aborts with err.
    sel       = 1'b0;
    stuck_arm = 1'b1;
    d0        = n_done;
    sb.push_back({K_RD, 12'h060});
    sb.push_back({K_S1, 12'h000});
    sb.push_back({K_DN, 12'h000});
    pulse_start(2, 12'h060, 12'h600);
    wait_done(d0);
    chk("err_timeout", 64'(mon_err), 64'd1);
    stuck_arm = 1'b0;
    repeat (3) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_seq.md
# norm_seq

Sequencer for the RMSNorm-1 controller over a hidden dimension wider than one K-column tile. It walks the tiles of the current M-row block and reads each input tile from activation SRAM. It pulses the controller's three phase starts (square/accumulate, sum/rsqrt, scale) in order, waits out the controller's busy window after each one, and writes each normalised tile back to SRAM. It sits between the layer-level top FSM and the norm controller / PE array.

## Interface
- ADDR_W, 12, SRAM tile address width
- NT_W, 6, tile-count width
- RD_LAT, 1, SRAM read latency in cycles, 1..3
- TIMEOUT, 64, watchdog limit in cycles per busy wait (only with the macro)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_start  in  1  pulse; begin a norm pass
- cfg_ntile  in  NT_W  number of K-column tiles, 1..2^NT_W-1
- cfg_rd_base  in  ADDR_W  first input tile address
- cfg_wr_base  in  ADDR_W  first output tile address
- busy_norm1  in  1  norm controller busy
- start1 / start1_sum / start2  out  1 each  registered single-cycle phase pulses
- sram_rd_en / sram_wr_en  out  1  registered read/write strobes
- sram_rd_addr / sram_wr_addr  out  ADDR_W  registered addresses
- busy  out  1  pass in progress
- done  out  1  single-cycle pulse at end of pass
- err  out  1  sticky error flag

## Operation
- Reset: all outputs 0, state IDLE, tile counter t=0. Reset mid-pass aborts with no further strobes.
- Arguments are latched on an accepted cfg_start. cfg_start is accepted only in IDLE, and acceptance clears err.
- cfg_start while busy is ignored and sets err.
- cfg_ntile=0 emits no strobes and no starts. done pulses the next cycle and err sets.
- States: IDLE -> RD1 -> LAT1 -> ISS1 -> WAIT1 -> (t<ntile-1: t++, RD1 | else SUM) -> WAITS -> RD2 -> LAT2 -> ISS2 -> WAIT2 -> WB -> (t<ntile-1: t++, RD2 | else DONE) -> IDLE.
- RD1 / RD2: sram_rd_en=1 for one cycle at address cfg_rd_base+t, mod 2^ADDR_W (wraps).
- LAT1 / LAT2: hold for RD_LAT-1 cycles. With RD_LAT=1 the state is skipped.
- ISS1 pulses start1; ISS2 pulses start2; SUM pulses start1_sum and resets t to 0.
- Busy waits (WAIT1/WAITS/WAIT2):
  - busy_norm1 is ignored in the first cycle after the start pulse, because the controller registers busy.
  - Afterwards the wait exits on the first cycle busy_norm1 is sampled 0.
- WB: sram_wr_en=1 for one cycle at address cfg_wr_base+t.
- DONE: done=1 for one cycle, busy drops to 0, return to IDLE.
- At most one of start1/start1_sum/start2 is high in any cycle.
- Read and write strobes never overlap.

## Timing
- busy is high from the cycle after cfg_start is accepted through the DONE cycle inclusive.
- Read to start: sram_rd_en in cycle n; the start pulse is in cycle n+RD_LAT.
- Start to wait: the start pulse is in cycle s; busy_norm1 is first evaluated in cycle s+2.
- Write-back: sram_wr_en is asserted the cycle after WAIT2 exits, when the scaled tile is in the controller's output buffer.
- Per-tile overhead beyond the controller's busy window: RD_LAT+2 cycles in phase 1; RD_LAT+3 cycles in phase 3.
- busy_norm1 already low at the first evaluated cycle: the wait exits immediately. A zero-length busy is legal.

## Configuration
- NORM_SEQ_TIMEOUT_EN defined:
  - Each busy wait carries a down-counter loaded with TIMEOUT.
  - If busy_norm1 is still 1 when the counter expires, the pass aborts: err=1, done pulses once, return to IDLE, no further strobes.
- Undefined: no counter is built, and the waits are unbounded.

## Test plan
- RD_LAT=1, ntile=2, rd_base=0x010, wr_base=0x100, controller model busy for 19/6/4 cycles:
  - Reads at 0x010, 0x011, 0x010, 0x011; writes at 0x100, 0x101.
  - Pulse order start1, start1, start1_sum, start2, start2; exactly one done.
- ntile=1, rd_base=0xFFF, wr_base=0xFFF, RD_LAT=3: read at 0xFFF; start1 exactly 3 cycles after sram_rd_en; write at 0xFFF; no wrap misbehaviour.
- cfg_start mid-pass (at the first WAIT1) -> ignored, err=1, pass completes normally; next cfg_start clears err.
- ntile=0 -> no strobes or starts, done 1 cycle after cfg_start, err=1.
- rst_n low during WAITS -> all outputs 0 on the next edge, no start2 issued; a new pass after reset runs cleanly.
- NORM_SEQ_TIMEOUT_EN, TIMEOUT=8, busy_norm1 stuck at 1 after start1 -> err=1, done pulses once, IDLE, no start1_sum.
